vga_text_writer: RTL and testbench
==================================

// Module: vga_text_writer
// PURPOSE
//  CPU-side writer for the 80x25 text buffer scanned out by the VGA adapter.
//  Accepts a byte stream (valid/ready) and writes char/attr pairs into video RAM.
//  Executes control codes, auto-wraps and hardware-scrolls the screen.
//  Drives cursor_x/cursor_y to the adapter. Cell (x,y) sits at 2*(x+80*y): char at even address, attr at odd.
// PARAMETERS
//  COLS        80     columns per row; row stride is 2*COLS bytes
//  ROWS        25     rows per screen
//  CLEAR_ATTR  8'h07  attr byte written by scroll-fill and clear
// PORTS
//  CLK25      in   1   25 MHz clock, single clock domain
//  RST_N      in   1   asynchronous active-low reset
//  in_data    in   8   byte to print or control code
//  in_attr    in   8   attr for in_data, sampled together with it
//  in_valid   in   1   in_data/in_attr valid
//  in_ready   out  1   writer can accept; transfer = in_valid & in_ready
//  mem_addr   out  12  video RAM address
//  mem_wdata  out  8   video RAM write data
//  mem_we     out  1   video RAM write strobe
//  mem_rdata  in   8   video RAM read data, 1-cycle latency after mem_addr
//  cursor_x   out  8   cursor column 0..COLS-1
//  cursor_y   out  8   cursor row 0..ROWS-1
//  busy       out  1   high while scrolling or clearing
// BEHAVIOUR
//  Reset values:
//   - in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0
//   - cursor_x=0, cursor_y=0, busy=0, state=IDLE
//  Reset mid-operation aborts at once. No further writes occur. Partial scroll/clear is left as is.
//  in_ready=1 only in IDLE. Data and attr are captured into internal regs on transfer.
//  States:
//   - IDLE: on transfer, decode in_data.
//   - WR_CHAR: we=1, addr=2*(x+COLS*y), wdata=char.
//   - WR_ATTR: we=1, addr|=1, wdata=attr. Then advance cursor.
//   - SC_RD: addr=src. SC_WR: addr=src-2*COLS, wdata=mem_rdata, we=1, src+=1.
//     Loop SC_RD/SC_WR for src=2*COLS..2*COLS*ROWS-1, i.e. 2 cycles/byte.
//   - FILL: one byte per cycle over [lo,hi). Even address writes 8'h20, odd writes CLEAR_ATTR.
//  Decode:
//   - 0x20..0xFF: printable. IDLE->WR_CHAR->WR_ATTR->IDLE (3 cycles per char).
//   - 0x0D CR: x=0, stay IDLE, no RAM write.
//   - 0x0A LF: if y<ROWS-1 then y+1; else scroll. x unchanged.
//   - 0x08 BS: if x>0 then x-1; at x=0 no change. No erase.
//   - 0x0C FF: FILL 0..2*COLS*ROWS-1 (4000 bytes), then x=y=0.
//   - Other 0x00..0x1F: ignored; one-cycle accept only.
//  Advance after WR_ATTR:
//   - x<COLS-1: x+1.
//   - x==COLS-1: x=0 and y+1. If y==ROWS-1, y stays and scroll starts.
//  Scroll:
//   - SC copy of 3840 bytes, then FILL of last row (3840..3999).
//   - Total 7680+160 cycles. busy=1 throughout. Back to IDLE.
//  mem_we is high only in WR_CHAR, WR_ATTR, SC_WR and FILL.
//  mem_addr never exceeds 2*COLS*ROWS-1. Attr area 0xFA0+ is never touched.
//  Cursor updates in the cycle that leaves WR_ATTR, or in the accept cycle for CR/BS.
// TESTING
//  - Reset, then 'A'(0x41) with attr 0x1E: writes [0]=0x41, [1]=0x1E. cursor_x=1. in_ready low for exactly 2 cycles.
//  - 80 printable bytes from (0,0): last write at addr 158/159. Cursor ends at (0,1).
//  - Fill rows with row index, cursor (79,24), print 'Z':
//    row r holds old r+1; row 24 is 0x20/0x07 pairs; [3838]='Z'; cursor (0,24); busy 7840 cycles.
//  - CR at (5,3) -> (0,3). BS at (0,3) -> (0,3). BS at (5,3) -> (4,3). No mem_we for any of these.
//  - FF: 4000 writes alternating 0x20/0x07, cursor (0,0). in_valid held high during busy is not accepted.
//  - Assert RST_N low mid-scroll: mem_we=0 immediately, cursor (0,0), in_ready=1 after release.

Source files
------------

// File: rtl/vga_text_writer.sv
// rtl/vga_text_writer.sv - byte-stream writer for the 80x25 VGA text buffer
//
// Prints a valid/ready byte stream into video RAM as char/attr pairs, executes
// CR/LF/BS/FF, wraps at end of line and hardware-scrolls at the bottom row.
//
// Ports:
//   CLK25      in   1   clock, single domain
//   RST_N      in   1   asynchronous active-low reset
//   in_data    in   8   byte to print or control code
//   in_attr    in   8   attribute for in_data
//   in_valid   in   1   input byte valid
//   in_ready   out  1   writer can accept (IDLE only)
//   mem_addr   out  12  video RAM address
//   mem_wdata  out  8   video RAM write data
//   mem_we     out  1   video RAM write strobe
//   mem_rdata  in   8   video RAM read data, one cycle after mem_addr
//   cursor_x   out  8   cursor column
//   cursor_y   out  8   cursor row
//   busy       out  1   scrolling or clearing
module vga_text_writer #(
   parameter int          COLS       = 80,
   parameter int          ROWS       = 25,
   parameter logic [7:0]  CLEAR_ATTR = 8'h07
) (
   input  logic        CLK25,
   input  logic        RST_N,
   input  logic [7:0]  in_data,
   input  logic [7:0]  in_attr,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [11:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  cursor_x,
   output logic [7:0]  cursor_y,
   output logic        busy
);

   localparam logic [11:0] L_STRIDE   = 12'(2 * COLS);
   localparam logic [11:0] L_END      = 12'(2 * COLS * ROWS);
   localparam logic [11:0] L_LAST_ROW = L_END - L_STRIDE;
   localparam logic [11:0] L_LAST_B   = L_END - 12'd1;
   localparam logic [7:0]  L_XMAX     = 8'(COLS - 1);
   localparam logic [7:0]  L_YMAX     = 8'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_CHAR, S_WR_ATTR, S_SC_RD, S_SC_WR, S_FILL
   } state_t;

   state_t      r_state, w_next;
   logic [7:0]  r_char, r_attr, r_x, r_y;
   logic [11:0] r_ptr;      // scroll source address, or fill address
   logic        r_home;     // fill came from FF: home the cursor when done
   logic [11:0] w_cell, w_char_addr;
   logic        w_wrap, w_bottom, w_last;

   assign w_cell      = 12'(r_y) * 12'(COLS) + 12'(r_x);
   assign w_char_addr = {w_cell[10:0], 1'b0};
   assign w_wrap      = (r_x == L_XMAX);
   assign w_bottom    = (r_y == L_YMAX);
   assign w_last      = (r_ptr == L_LAST_B);
   assign cursor_x    = r_x;
   assign cursor_y    = r_y;

   always_ff @(posedge CLK25 or negedge RST_N) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               if (in_data >= 8'h20)                  w_next = S_WR_CHAR;
               else if (in_data == 8'h0A && w_bottom) w_next = S_SC_RD;
               else if (in_data == 8'h0C)             w_next = S_FILL;
            end
         end
         S_WR_CHAR: w_next = S_WR_ATTR;
         S_WR_ATTR: w_next = (w_wrap && w_bottom) ? S_SC_RD : S_IDLE;
         S_SC_RD:   w_next = S_SC_WR;
         S_SC_WR:   w_next = w_last ? S_FILL : S_SC_RD;
         S_FILL:    w_next = w_last ? S_IDLE : S_FILL;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 12'd0;
      mem_wdata = 8'd0;
      busy      = 1'b0;
      case (r_state)
         S_IDLE: in_ready = 1'b1;
         S_WR_CHAR: begin
            mem_we    = 1'b1;
            mem_addr  = w_char_addr;
            mem_wdata = r_char;
         end
         S_WR_ATTR: begin
            mem_we    = 1'b1;
            mem_addr  = w_char_addr | 12'd1;
            mem_wdata = r_attr;
         end
         S_SC_RD: begin
            busy     = 1'b1;
            mem_addr = r_ptr;
         end
         S_SC_WR: begin
            // mem_rdata now holds the byte addressed in SC_RD
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_ptr - L_STRIDE;
            mem_wdata = mem_rdata;
         end
         S_FILL: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_ptr;
            mem_wdata = r_ptr[0] ? CLEAR_ATTR : 8'h20;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK25 or negedge RST_N) begin
      if (!RST_N) begin
         r_char <= 8'd0;
         r_attr <= 8'd0;
         r_x    <= 8'd0;
         r_y    <= 8'd0;
         r_ptr  <= 12'd0;
         r_home <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_char <= in_data;
                  r_attr <= in_attr;
                  case (in_data)
                     8'h0D: r_x <= 8'd0;
                     8'h0A: begin
                        if (!w_bottom) r_y <= r_y + 8'd1;
                        else           r_ptr <= L_STRIDE;
                     end
                     8'h08: if (r_x != 8'd0) r_x <= r_x - 8'd1;
                     8'h0C: begin
                        r_ptr  <= 12'd0;
                        r_home <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            S_WR_ATTR: begin
               if (!w_wrap) begin
                  r_x <= r_x + 8'd1;
               end else begin
                  r_x <= 8'd0;
                  if (!w_bottom) r_y <= r_y + 8'd1;
                  else           r_ptr <= L_STRIDE;
               end
            end
            S_SC_WR: r_ptr <= w_last ? L_LAST_ROW : r_ptr + 12'd1;
            S_FILL: begin
               r_ptr <= r_ptr + 12'd1;
               if (w_last && r_home) begin
                  r_x    <= 8'd0;
                  r_y    <= 8'd0;
                  r_home <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_text_writer.sv
// tb/tb_vga_text_writer.sv - scoreboard bench for vga_text_writer
module tb_vga_text_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic [7:0]  in_attr = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata = 8'd0;
   logic [7:0]  cursor_x, cursor_y;
   logic        busy;

   vga_text_writer dut (
      .CLK25(clk), .RST_N(rst_n),
      .in_data(in_data), .in_attr(in_attr), .in_valid(in_valid), .in_ready(in_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
   );

   always #20 clk = ~clk;

   logic [7:0]  ram   [0:4095];
   logic [7:0]  model [0:4095];
   logic [19:0] exp_q [$];
   int          n_cmp = 0;
   int          n_err = 0;
   bit          skip  = 1'b0;
   int          mx = 0, my = 0;
   int          last_low, last_bsy;

   // video RAM with registered read
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // monitor: every RAM write is popped against the scoreboard
   always @(negedge clk) begin
      if (rst_n && mem_we && !skip) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: addr=%0d data=0x%0h, no write expected", mem_addr, mem_wdata);
         end else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               n_err++;
               $display("FAIL mem_write: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                        mem_addr, mem_wdata, e[19:8], e[7:0]);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic push_wr(input int a, input logic [7:0] d);
      exp_q.push_back({12'(a), d});
      model[a] = d;
   endtask

   task automatic push_scroll();
      for (int s = 160; s < 4000; s++) push_wr(s - 160, model[s]);
      for (int f = 3840; f < 4000; f++) push_wr(f, (f % 2) ? 8'h07 : 8'h20);
   endtask

   task automatic send(input logic [7:0] b, input logic [7:0] a);
      int t;
      @(negedge clk);
      in_data  = b;
      in_attr  = a;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) check("accept_timeout", t, 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      last_low = 0;
      last_bsy = 0;
      @(negedge clk);
      while (!in_ready && last_low < 20000) begin
         last_low++;
         if (busy) last_bsy++;
         @(negedge clk);
      end
      if (last_low >= 20000) check("idle_timeout", last_low, 0);
   endtask

   // push the expected writes for one byte, update the cursor model, then drive it
   task automatic put(input logic [7:0] b, input logic [7:0] a);
      if (b >= 8'h20) begin
         push_wr(2 * (mx + 80 * my), b);
         push_wr(2 * (mx + 80 * my) + 1, a);
         if (mx < 79) mx++;
         else begin
            mx = 0;
            if (my < 24) my++;
            else push_scroll();
         end
      end else if (b == 8'h0D) begin
         mx = 0;
      end else if (b == 8'h0A) begin
         if (my < 24) my++;
         else push_scroll();
      end else if (b == 8'h08) begin
         if (mx > 0) mx--;
      end else if (b == 8'h0C) begin
         for (int i = 0; i < 4000; i++) push_wr(i, (i % 2) ? 8'h07 : 8'h20);
         mx = 0;
         my = 0;
      end
      send(b, a);
      wait_idle();
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 4096; i++) begin
         ram[i]   = 8'h00;
         model[i] = 8'h00;
      end
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_cursor_x", cursor_x, 0);
      check("rst_cursor_y", cursor_y, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;

      // single printable character
      put(8'h41, 8'h1E);
      check("A_ready_low", last_low, 2);
      check("A_cursor_x", cursor_x, 1);
      check("A_cursor_y", cursor_y, 0);
      check("A_ram0", ram[0], 8'h41);
      check("A_ram1", ram[1], 8'h1E);

      // full line wraps to next row
      put(8'h0D, 8'h00);
      check("cr_home_x", cursor_x, 0);
      for (int i = 0; i < 80; i++) put(8'(8'h21 + i), 8'h17);
      check("line_cursor_x", cursor_x, 0);
      check("line_cursor_y", cursor_y, 1);
      check("line_ram158", ram[158], 8'h70);
      check("line_ram159", ram[159], 8'h17);

      // CR / BS at (5,3) and (0,3)
      put(8'h0A, 8'h00);
      put(8'h0A, 8'h00);
      for (int i = 0; i < 5; i++) put(8'h62, 8'h02);
      check("pre_cr_x", cursor_x, 5);
      put(8'h0D, 8'h00);
      check("cr_ready_low", last_low, 0);
      check("cr_x", cursor_x, 0);
      check("cr_y", cursor_y, 3);
      put(8'h08, 8'h00);
      check("bs0_x", cursor_x, 0);
      check("bs0_y", cursor_y, 3);
      for (int i = 0; i < 5; i++) put(8'h63, 8'h03);
      put(8'h08, 8'h00);
      check("bs5_x", cursor_x, 4);
      check("bs5_y", cursor_y, 3);
      put(8'h11, 8'h00);
      check("ctl_ignored_x", cursor_x, 4);
      check("q_empty_1", exp_q.size(), 0);

      // scroll: rows preloaded with row index, print 'Z' at (79,24)
      put(8'h0D, 8'h00);
      for (int i = 0; i < 21; i++) put(8'h0A, 8'h00);
      for (int i = 0; i < 79; i++) put(8'h61, 8'h01);
      check("pos_x", cursor_x, 79);
      check("pos_y", cursor_y, 24);
      for (int i = 0; i < 4000; i++) begin
         ram[i]   = 8'(i / 160);
         model[i] = 8'(i / 160);
      end
      put(8'h5A, 8'h4E);
      check("scroll_busy_cycles", last_bsy, 7840);
      check("scroll_ready_low", last_low, 7842);
      check("scroll_x", cursor_x, 0);
      check("scroll_y", cursor_y, 24);
      check("scroll_ram3838", ram[3838], 8'h5A);
      check("scroll_ram3839", ram[3839], 8'h4E);
      check("scroll_ram0", ram[0], 1);
      check("scroll_ram3520", ram[3520], 23);
      check("scroll_ram3840", ram[3840], 8'h20);
      check("scroll_ram3999", ram[3999], 8'h07);
      check("q_empty_2", exp_q.size(), 0);

      // FF with in_valid held through the clear
      for (int i = 0; i < 4000; i++) push_wr(i, (i % 2) ? 8'h07 : 8'h20);
      push_wr(0, 8'h51);
      push_wr(1, 8'h2F);
      @(negedge clk);
      in_data  = 8'h0C;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_data = 8'h51;
      in_attr = 8'h2F;
      cyc = 0;
      @(negedge clk);
      while (!in_ready && cyc < 5000) begin
         cyc++;
         @(negedge clk);
      end
      check("ff_busy_cycles", cyc, 4000);
      check("ff_x", cursor_x, 0);
      check("ff_y", cursor_y, 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      mx = 1;
      my = 0;
      wait_idle();
      check("ff_q_x", cursor_x, 1);
      check("ff_q_y", cursor_y, 0);
      check("q_empty_3", exp_q.size(), 0);

      // reset in the middle of a scroll
      for (int i = 0; i < 24; i++) put(8'h0A, 8'h00);
      check("bottom_y", cursor_y, 24);
      skip = 1'b1;
      send(8'h0A, 8'h00);
      repeat (100) @(negedge clk);
      check("midscroll_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("rstmid_mem_we", mem_we, 0);
      check("rstmid_x", cursor_x, 0);
      check("rstmid_y", cursor_y, 0);
      check("rstmid_busy", busy, 0);
      @(negedge clk);
      check("rstmid_mem_we_held", mem_we, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstmid_in_ready", in_ready, 1);
      check("rstmid_we_after", mem_we, 0);
      skip = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
